ps2_key_decoder: RTL
====================

# ps2_key_decoder

Converts the raw PS/2 scan-code byte stream (set 2) coming out of the keyboard receiver into clean game events for the whack-a-mole core. It tracks make/break/extended prefixes, maps nine playing keys to hole indices 0-8, suppresses typematic repeats, and emits one-cycle strobes for a new hit, start (Enter) and pause (Esc). It sits directly downstream of the PS/2 receiver and upstream of the game FSM.

## Interface
- `TIMEOUT_CYCLES`, default 2_000_000: idle `clk` cycles tolerated inside a prefix sequence before aborting it (20 ms at 100 MHz).
- `clk` in 1: system clock, the same clock as the receiver.
- `rst` in 1: synchronous, active-high reset.
- `byte_in` in 8: newest scan-code byte (the receiver's `keycode[7:0]`).
- `byte_valid` in 1: one-cycle strobe, `byte_in` is valid (the receiver's `oflag`).
- `hit_valid` out 1: one-cycle strobe for a new press of a playing key.
- `hit_idx` out 4: hole index 0-8; valid with `hit_valid`, holds its last value otherwise.
- `held` out 9: bitmap of playing keys currently held down.
- `start_pulse` out 1: one-cycle strobe on an Enter make code (0x5A) that is not a repeat.
- `pause_pulse` out 1: one-cycle strobe on an Esc make code (0x76) that is not a repeat.
- `seq_err` out 1: one-cycle strobe when a prefix sequence times out.

## Operation
- Keymap: Q 0x15 maps to 0, W 0x1D to 1, E 0x24 to 2, A 0x1C to 3, S 0x1B to 4, D 0x23 to 5, Z 0x1A to 6, X 0x22 to 7, C 0x21 to 8. Every other code is "other".
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
- IDLE:
  - F0 goes to BRK.
  - E0 goes to EXT.
  - A mapped code with `held[i]`=0 sets `held[i]`, pulses `hit_valid`, and sets `hit_idx`=i.
  - A mapped code with `held[i]`=1 is a repeat: no pulse.
  - Enter and Esc pulse their strobes unless repeated; 1-bit held flags are kept for Enter and Esc.
- BRK:
  - A mapped code clears `held[i]` and returns to IDLE.
  - Enter or Esc clears its held flag and returns to IDLE.
  - Other codes return to IDLE with no effect.
  - F0 stays in BRK.
  - E0 goes to EXT.
- EXT:
  - F0 goes to EXT_BRK.
  - E0 stays in EXT.
  - Any other byte returns to IDLE with no event; extended keys are ignored.
- EXT_BRK: any non-prefix byte returns to IDLE with no event; E0 goes to EXT.
- Control bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF, in any state: go to IDLE with no event. 0xAA (keyboard BAT/reset) additionally clears `held` and both held flags.
- Break code for a key that is not held: no change.
- Timeout counter:
  - Runs only in a non-IDLE state and reloads on every `byte_valid`.
  - When it reaches `TIMEOUT_CYCLES`-1: go to IDLE and pulse `seq_err`. `held` is unchanged.
  - Width is $clog2(`TIMEOUT_CYCLES`).

## Timing
- All outputs are registered. `byte_valid` sampled at edge N produces its effects (strobes, `held`, state) visible after edge N; strobes last exactly one cycle.
- Latency is 1 cycle; throughput is one byte per cycle. Back-to-back `byte_valid` is legal even though PS/2 never produces it.
- `byte_valid` arriving in the same cycle as timeout expiry: the byte is processed in the current state and the timeout is suppressed (no `seq_err`).
- Reset values: state IDLE, `held`=0, `hit_idx`=0, all strobes 0, held flags 0, counter 0.
- Reset mid-sequence discards any pending prefix. A `byte_valid` in the reset cycle is ignored.
- At most one of `hit_valid`, `start_pulse` and `pause_pulse` is high in any cycle.

## Structure
- Shared package `ps2_kbd_pkg` holds:
  - scan-code constants (F0, E0, the control bytes, Enter, Esc, the nine key codes);
  - the FSM state enum;
  - `NUM_KEYS`=9.
- One natural sub-module, `ps2_keymap`: combinational, `code[7:0]` in; `is_key`, `idx[3:0]` out. It is reused later by the score display for key labels.
- Target size is roughly 150-250 lines of RTL in total.

## Test plan
- Bytes 0x1C, then 0x1C, 0x1C (repeats), then F0 0x1C. Required: `hit_valid` exactly once with `hit_idx`=3; `held`=9'h008 until the final 0x1C, then 0.
- Press Q and C, release Q. Required: hits for idx 0 and idx 8; `held` goes 001, then 101, then 100.
- E0 0x75 then E0 F0 0x75 (extended up-arrow). Required: no strobes, `held` unchanged, FSM back in IDLE.
- F0 with no following byte for `TIMEOUT_CYCLES` (use 16 in simulation). Required: `seq_err` one cycle after the 15th idle cycle; the next 0x15 gives a hit with idx 0.
- Hold W (0x1D), then 0xAA. Required: `held` clears to 0. Then 0x5A, 0x5A, 0x76: `start_pulse` once, `pause_pulse` once.
- Assert `rst` between F0 and 0x24 while E is held. Required: `held`=0, no strobes; the following 0x24 produces a hit with idx 2.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// ps2_kbd_pkg: shared definitions for the PS/2 keyboard decoding path.
//   - set-2 scan-code constants (prefixes, control bytes, Enter, Esc, play keys)
//   - decoder FSM state enum
//   - NUM_KEYS: number of playing keys / holes
package ps2_kbd_pkg;

    localparam int NUM_KEYS = 9;

    // Prefix bytes
    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;

    // Control / status bytes from the keyboard
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ECHO   = 8'hEE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Game control keys
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_ESC    = 8'h76;

    // Playing keys, hole order 0..8
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_E      = 8'h24;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_C      = 8'h21;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BRK     = 2'd1,
        ST_EXT     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    // Bytes that never belong to a key sequence; they abort any prefix.
    function automatic logic is_control(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == SC_ECHO) || (b == SC_ERR0) || (b == SC_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: byte stream in, game events out.
// Handshake: byte_valid is a one-cycle strobe qualifying byte_in; there is no
// ready, the decoder accepts one byte every cycle. hit_valid, start_pulse,
// pause_pulse and seq_err are one-cycle strobes; hit_idx is qualified by
// hit_valid and holds otherwise; held and dbg_state are level outputs.
//   master: byte source / event consumer
//   slave : the decoder
interface ps2_key_decoder_if;
    import ps2_kbd_pkg::*;

    logic [7:0]          byte_in;
    logic                byte_valid;
    logic                hit_valid;
    logic [3:0]          hit_idx;
    logic [NUM_KEYS-1:0] held;
    logic                start_pulse;
    logic                pause_pulse;
    logic                seq_err;
    state_t              dbg_state;

    modport master (
        output byte_in, byte_valid,
        input  hit_valid, hit_idx, held, start_pulse, pause_pulse, seq_err, dbg_state
    );

    modport slave (
        input  byte_in, byte_valid,
        output hit_valid, hit_idx, held, start_pulse, pause_pulse, seq_err, dbg_state
    );

endinterface

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational scan-code to hole-index lookup.
//   code   in  8 : set-2 scan code
//   is_key out 1 : code is one of the nine playing keys
//   idx    out 4 : hole index 0-8 (0 when is_key is low)
module ps2_keymap
    import ps2_kbd_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_key,
    output logic [3:0] idx
);

    always_comb begin
        is_key = 1'b1;
        idx    = 4'd0;
        case (code)
            SC_Q:    idx = 4'd0;
            SC_W:    idx = 4'd1;
            SC_E:    idx = 4'd2;
            SC_A:    idx = 4'd3;
            SC_S:    idx = 4'd4;
            SC_D:    idx = 4'd5;
            SC_Z:    idx = 4'd6;
            SC_X:    idx = 4'd7;
            SC_C:    idx = 4'd8;
            default: is_key = 1'b0;
        endcase
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the set-2 scan-code byte stream into game events.
// Tracks make/break/extended prefixes, keeps a held bitmap for the nine
// playing keys, suppresses typematic repeats and aborts stale prefixes.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : ps2_key_decoder_if.slave (byte_in/byte_valid in; hit_valid,
//              hit_idx, held, start_pulse, pause_pulse, seq_err, dbg_state out)
//   TIMEOUT_CYCLES : idle cycles tolerated inside a prefix sequence (>= 2)
module ps2_key_decoder
    import ps2_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic            clk,
    input  logic            rst,
    ps2_key_decoder_if.slave bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Expiry happens on the edge where the counter would reach TIMEOUT_CYCLES-1.
    localparam logic [CW-1:0] CNT_EXPIRE = CW'(TIMEOUT_CYCLES - 2);

    state_t              state_q, state_d;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic                enter_held_q, enter_held_d;
    logic                esc_held_q, esc_held_d;
    logic                hit_valid_q, hit_valid_d;
    logic [3:0]          hit_idx_q, hit_idx_d;
    logic                start_q, start_d;
    logic                pause_q, pause_d;
    logic                seq_err_q, seq_err_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                km_is_key;
    logic [3:0]          km_idx;

    ps2_keymap u_keymap (
        .code   (bus.byte_in),
        .is_key (km_is_key),
        .idx    (km_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            held_q       <= '0;
            enter_held_q <= 1'b0;
            esc_held_q   <= 1'b0;
            hit_valid_q  <= 1'b0;
            hit_idx_q    <= 4'd0;
            start_q      <= 1'b0;
            pause_q      <= 1'b0;
            seq_err_q    <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            held_q       <= held_d;
            enter_held_q <= enter_held_d;
            esc_held_q   <= esc_held_d;
            hit_valid_q  <= hit_valid_d;
            hit_idx_q    <= hit_idx_d;
            start_q      <= start_d;
            pause_q      <= pause_d;
            seq_err_q    <= seq_err_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        held_d       = held_q;
        enter_held_d = enter_held_q;
        esc_held_d   = esc_held_q;
        hit_valid_d  = 1'b0;
        hit_idx_d    = hit_idx_q;
        start_d      = 1'b0;
        pause_d      = 1'b0;
        seq_err_d    = 1'b0;
        cnt_d        = '0;

        if (bus.byte_valid) begin
            // A byte always wins over a coinciding timeout; counter reloads.
            if (is_control(bus.byte_in)) begin
                state_d = ST_IDLE;
                if (bus.byte_in == SC_BAT) begin
                    held_d       = '0;
                    enter_held_d = 1'b0;
                    esc_held_d   = 1'b0;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.byte_in == SC_BRK) begin
                            state_d = ST_BRK;
                        end else if (bus.byte_in == SC_EXT) begin
                            state_d = ST_EXT;
                        end else if (km_is_key) begin
                            if (!held_q[km_idx]) begin
                                held_d[km_idx] = 1'b1;
                                hit_valid_d    = 1'b1;
                                hit_idx_d      = km_idx;
                            end
                        end else if (bus.byte_in == SC_ENTER) begin
                            start_d      = !enter_held_q;
                            enter_held_d = 1'b1;
                        end else if (bus.byte_in == SC_ESC) begin
                            pause_d    = !esc_held_q;
                            esc_held_d = 1'b1;
                        end
                    end
                    ST_BRK: begin
                        if (bus.byte_in == SC_BRK) begin
                            state_d = ST_BRK;
                        end else if (bus.byte_in == SC_EXT) begin
                            state_d = ST_EXT;
                        end else begin
                            state_d = ST_IDLE;
                            if (km_is_key) begin
                                held_d[km_idx] = 1'b0;
                            end else if (bus.byte_in == SC_ENTER) begin
                                enter_held_d = 1'b0;
                            end else if (bus.byte_in == SC_ESC) begin
                                esc_held_d = 1'b0;
                            end
                        end
                    end
                    ST_EXT: begin
                        if (bus.byte_in == SC_BRK)      state_d = ST_EXT_BRK;
                        else if (bus.byte_in == SC_EXT) state_d = ST_EXT;
                        else                            state_d = ST_IDLE;
                    end
                    ST_EXT_BRK: begin
                        if (bus.byte_in == SC_EXT)      state_d = ST_EXT;
                        else if (bus.byte_in == SC_BRK) state_d = ST_EXT_BRK;
                        else                            state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q != ST_IDLE) begin
            if (cnt_q == CNT_EXPIRE) begin
                state_d   = ST_IDLE;
                seq_err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign bus.hit_valid   = hit_valid_q;
    assign bus.hit_idx     = hit_idx_q;
    assign bus.held        = held_q;
    assign bus.start_pulse = start_q;
    assign bus.pause_pulse = pause_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.dbg_state   = state_q;

endmodule
